systolic_fpga_example_axis_scale_sat: RTL and testbench

//  Lane-wise scale/bias/shift/saturate compute stage on kernel AXI4-Stream data.

---
 rtl/systolic_fpga_example_axis_scale_sat.sv | 181 ++++++++++++++++++
 tb/tb_systolic_fpga_example_axis_scale_sat.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_fpga_example_axis_scale_sat.sv
// Lane-wise scale/bias/shift/saturate stage on an AXI4-Stream.
// Two-stage pipeline with a global stall, run-based control.
module systolic_fpga_example_axis_scale_sat #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_LANE_WIDTH       = 32,
  parameter int unsigned C_SHIFT_WIDTH      = 6
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic                            ctrl_start,
  input  logic [C_LANE_WIDTH-1:0]         ctrl_scale,
  input  logic [2*C_LANE_WIDTH-1:0]       ctrl_bias,
  input  logic [C_SHIFT_WIDTH-1:0]        ctrl_shift,
  output logic                            ctrl_done,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [31:0]                     stat_beat_count,
  output logic [31:0]                     stat_sat_count
);

  localparam int unsigned N    = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
  localparam int unsigned PW   = 2 * C_LANE_WIDTH;
  localparam int unsigned SumW = PW + 1;
  localparam int unsigned SatW = $clog2(N + 1);

  localparam logic signed [SumW-1:0] LaneMax =
      {{(SumW - C_LANE_WIDTH + 1){1'b0}}, {(C_LANE_WIDTH - 1){1'b1}}};
  localparam logic signed [SumW-1:0] LaneMin =
      {{(SumW - C_LANE_WIDTH + 1){1'b1}}, {(C_LANE_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Async assert, synchronous deassert of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                     state_q;
  logic                       done_q;
  logic                       open_q;
  logic [C_LANE_WIDTH-1:0]    scale_q;
  logic [PW-1:0]              bias_q;
  logic [C_SHIFT_WIDTH-1:0]   shift_q;
  logic [31:0]                beat_cnt_q;
  logic [31:0]                sat_cnt_q;

  logic                       v1_q, last1_q;
  logic [N-1:0][PW-1:0]       p1_q;
  logic                       v2_q, last2_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] data2_q;
  logic [SatW-1:0]            sat2_q;

  logic en, accept, out_hs;

  assign en            = !v2_q || m_axis_tready;
  // open_q closes the input once the run's tlast beat has been taken.
  assign s_axis_tready = (state_q == StRun) && open_q && en;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_hs        = v2_q && m_axis_tready;

  // Stage 1: full-width signed product per lane.
  logic [N-1:0][PW-1:0] prod_d;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      prod_d[i] = {{C_LANE_WIDTH{s_axis_tdata[i*C_LANE_WIDTH + C_LANE_WIDTH - 1]}},
                   s_axis_tdata[i*C_LANE_WIDTH +: C_LANE_WIDTH]} *
                  {{C_LANE_WIDTH{scale_q[C_LANE_WIDTH-1]}}, scale_q};
    end
  end

  // Stage 2: bias and shift at one extra bit so the sum never wraps, then clamp.
  logic [N-1:0][SumW-1:0]        sum_d;
  logic [N-1:0][SumW-1:0]        shr_d;
  logic [N-1:0]                  sat_lane_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] res_d;
  logic [SatW-1:0]               sat_n_d;

  always_comb begin
    sum_d      = '0;
    shr_d      = '0;
    sat_lane_d = '0;
    res_d      = '0;
    sat_n_d    = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_d[i] = {p1_q[i][PW-1], p1_q[i]} + {bias_q[PW-1], bias_q};
      shr_d[i] = $signed(sum_d[i]) >>> shift_q;
      if ($signed(shr_d[i]) > LaneMax) begin
        res_d[i*C_LANE_WIDTH +: C_LANE_WIDTH] = LaneMax[C_LANE_WIDTH-1:0];
        sat_lane_d[i] = 1'b1;
      end else if ($signed(shr_d[i]) < LaneMin) begin
        res_d[i*C_LANE_WIDTH +: C_LANE_WIDTH] = LaneMin[C_LANE_WIDTH-1:0];
        sat_lane_d[i] = 1'b1;
      end else begin
        res_d[i*C_LANE_WIDTH +: C_LANE_WIDTH] = shr_d[i][C_LANE_WIDTH-1:0];
      end
      sat_n_d = sat_n_d + SatW'(sat_lane_d[i]);
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      p1_q    <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      data2_q <= '0;
      sat2_q  <= '0;
    end else if (en) begin
      v1_q    <= accept;
      last1_q <= accept && s_axis_tlast;
      p1_q    <= prod_d;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      data2_q <= res_d;
      sat2_q  <= sat_n_d;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      open_q     <= 1'b0;
      scale_q    <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ctrl_start) begin
            state_q    <= StRun;
            open_q     <= 1'b1;
            scale_q    <= ctrl_scale;
            bias_q     <= ctrl_bias;
            shift_q    <= ctrl_shift;
            beat_cnt_q <= '0;
            sat_cnt_q  <= '0;
          end
        end
        StRun: begin
          if (accept && s_axis_tlast) open_q <= 1'b0;
          if (out_hs) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            sat_cnt_q  <= sat_cnt_q + 32'(sat2_q);
            if (last2_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl_done       = done_q;
  assign m_axis_tvalid   = v2_q;
  assign m_axis_tdata    = data2_q;
  assign m_axis_tlast    = last2_q;
  assign stat_beat_count = beat_cnt_q;
  assign stat_sat_count  = sat_cnt_q;

endmodule

// File: tb/tb_systolic_fpga_example_axis_scale_sat.sv
// Scoreboard bench: stimulus pushes hand-computed expected beats, a monitor pops and compares.
module tb_systolic_fpga_example_axis_scale_sat;

  localparam int N = 16;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          ctrl_start;
  logic [31:0]   ctrl_scale;
  logic [63:0]   ctrl_bias;
  logic [5:0]    ctrl_shift;
  logic          ctrl_done;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [511:0]  s_axis_tdata;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [511:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic [31:0]   stat_beat_count;
  logic [31:0]   stat_sat_count;

  systolic_fpga_example_axis_scale_sat dut (
    .aclk            (aclk),
    .areset_n        (areset_n),
    .ctrl_start      (ctrl_start),
    .ctrl_scale      (ctrl_scale),
    .ctrl_bias       (ctrl_bias),
    .ctrl_shift      (ctrl_shift),
    .ctrl_done       (ctrl_done),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .stat_beat_count (stat_beat_count),
    .stat_sat_count  (stat_sat_count)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    first_acc = -1;
  int    first_out = -1;
  int    last_hs = -1;
  bit    rdy_rand = 1'b0;
  bit    rdy_level = 1'b1;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop on every output handshake; also enforce AXIS hold during stalls.
  logic         stall_prev = 1'b0;
  logic [511:0] data_prev;
  logic         last_prev;
  beat_t        e;

  always @(negedge aclk) begin
    if (areset_n) begin
      if (stall_prev) begin
        check("hold_valid", 512'(m_axis_tvalid), 512'(1));
        check("hold_data", m_axis_tdata, data_prev);
        check("hold_last", 512'(m_axis_tlast), 512'(last_prev));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.data);
          check("tlast", 512'(m_axis_tlast), 512'(e.last));
          if (first_out < 0) first_out = cyc;
          if (m_axis_tlast) last_hs = cyc;
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      data_prev  = m_axis_tdata;
      last_prev  = m_axis_tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic start_run(input logic [31:0] sc, input logic [63:0] bi, input logic [5:0] sh);
    @(posedge aclk);
    #1;
    ctrl_start = 1'b1;
    ctrl_scale = sc;
    ctrl_bias  = bi;
    ctrl_shift = sh;
    @(posedge aclk);
    #1;
    ctrl_start = 1'b0;
    first_acc  = -1;
    first_out  = -1;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic l);
    int k = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    @(negedge aclk);
    while (!s_axis_tready && k < 1000) begin
      @(negedge aclk);
      k++;
    end
    if (!s_axis_tready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got tready=0 expected tready=1");
    end else if (first_acc < 0) begin
      first_acc = cyc;
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic push(input logic [511:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic wait_done(input string name, input int beats, input int sats);
    int k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (!ctrl_done && k < 2000);
    if (!ctrl_done) begin
      tests++;
      fails++;
      $display("FAIL %s_done_timeout: got ctrl_done=0 expected 1", name);
    end else begin
      check({name, "_done_lat"}, 512'(cyc - last_hs), 512'(1));
      check({name, "_beats"}, 512'(stat_beat_count), 512'(beats));
      check({name, "_sats"}, 512'(stat_sat_count), 512'(sats));
      check({name, "_drained"}, 512'(exp_q.size()), 512'(0));
      @(negedge aclk);
      check({name, "_done_pulse"}, 512'(ctrl_done), 512'(0));
    end
  endtask

  logic [511:0] d, x;

  initial begin
    areset_n      = 1'b0;
    ctrl_start    = 1'b0;
    ctrl_scale    = '0;
    ctrl_bias     = '0;
    ctrl_shift    = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;

    #23;
    check("rst_mvalid", 512'(m_axis_tvalid), 512'(0));
    check("rst_mdata", m_axis_tdata, 512'(0));
    check("rst_mlast", 512'(m_axis_tlast), 512'(0));
    check("rst_done", 512'(ctrl_done), 512'(0));
    check("rst_sready", 512'(s_axis_tready), 512'(0));
    check("rst_stats", 512'({stat_beat_count, stat_sat_count}), 512'(0));
    areset_n = 1'b1;
    repeat (4) @(posedge aclk);

    // 1: identity, latency and done timing
    start_run(32'd1, 64'd0, 6'd0);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < N; i++) d[i*32 +: 32] = 32'(b * 16 + i);
      push(d, b == 3);
      send_beat(d, b == 3);
    end
    wait_done("t1", 4, 0);
    check("t1_latency", 512'(first_out - first_acc), 512'(2));

    // 2: (7*3-5)>>>1 = 8, (-7*3-5)>>>1 = -13
    start_run(32'd3, 64'hFFFF_FFFF_FFFF_FFFB, 6'd1);
    for (int i = 0; i < N; i++) begin
      d[i*32 +: 32] = (i % 2 == 0) ? 32'd7 : 32'hFFFF_FFF9;
      x[i*32 +: 32] = (i % 2 == 0) ? 32'd8 : 32'hFFFF_FFF3;
    end
    push(x, 1'b1);
    send_beat(d, 1'b1);
    wait_done("t2", 1, 0);

    // 3: saturation both ways, 16 lanes per beat
    start_run(32'h7FFF_FFFF, 64'd0, 6'd0);
    for (int i = 0; i < N; i++) begin
      d[i*32 +: 32] = 32'd2;
      x[i*32 +: 32] = 32'h7FFF_FFFF;
    end
    push(x, 1'b0);
    send_beat(d, 1'b0);
    for (int i = 0; i < N; i++) begin
      d[i*32 +: 32] = 32'hFFFF_FFFE;
      x[i*32 +: 32] = 32'h8000_0000;
    end
    push(x, 1'b1);
    send_beat(d, 1'b1);
    wait_done("t3", 2, 32);

    // Sum exceeds 64 bits: (2^62-2^32+1 + 2^63-1) >>> 33 = 0x5FFFFFFF
    start_run(32'h7FFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 6'd33);
    for (int i = 0; i < N; i++) begin
      d[i*32 +: 32] = 32'h7FFF_FFFF;
      x[i*32 +: 32] = 32'h5FFF_FFFF;
    end
    push(x, 1'b1);
    send_beat(d, 1'b1);
    wait_done("wide", 1, 0);

    // Large shift leaves only the sign
    start_run(32'd1, 64'd0, 6'd63);
    for (int i = 0; i < N; i++) begin
      d[i*32 +: 32] = (i % 2 == 0) ? 32'd5 : 32'hFFFF_FFFB;
      x[i*32 +: 32] = (i % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
    end
    push(x, 1'b1);
    send_beat(d, 1'b1);
    wait_done("shift63", 1, 0);

    // 4: random backpressure, 64 beats, x2
    rdy_rand = 1'b1;
    start_run(32'd2, 64'd0, 6'd0);
    for (int b = 0; b < 64; b++) begin
      for (int i = 0; i < N; i++) begin
        d[i*32 +: 32] = 32'(b * 16 + i - 500);
        x[i*32 +: 32] = 32'(2 * (b * 16 + i - 500));
      end
      push(x, b == 63);
      send_beat(d, b == 63);
    end
    wait_done("t4", 64, 0);
    rdy_rand = 1'b0;

    // 5: beats in IDLE refused; start during RUN ignored
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '1;
    s_axis_tlast  = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("t5_idle_ready", 512'(s_axis_tready), 512'(0));
    end
    s_axis_tvalid = 1'b0;
    start_run(32'd1, 64'd0, 6'd0);
    start_run(32'd5, 64'd100, 6'd2);
    for (int i = 0; i < N; i++) d[i*32 +: 32] = 32'd3;
    push(d, 1'b1);
    send_beat(d, 1'b1);
    wait_done("t5", 1, 0);

    // 6: reset with both pipeline stages full
    rdy_level = 1'b0;
    start_run(32'd1, 64'd0, 6'd0);
    for (int i = 0; i < N; i++) d[i*32 +: 32] = 32'(i + 1);
    send_beat(d, 1'b0);
    send_beat(d, 1'b0);
    @(negedge aclk);
    check("t6_full", 512'(m_axis_tvalid), 512'(1));
    @(posedge aclk);
    #3;
    areset_n = 1'b0;
    #1;
    check("t6_mvalid", 512'(m_axis_tvalid), 512'(0));
    check("t6_mdata", m_axis_tdata, 512'(0));
    check("t6_mlast", 512'(m_axis_tlast), 512'(0));
    check("t6_sready", 512'(s_axis_tready), 512'(0));
    check("t6_stats", 512'({stat_beat_count, stat_sat_count}), 512'(0));
    exp_q.delete();
    rdy_level = 1'b1;
    @(posedge aclk);
    #2;
    areset_n = 1'b1;
    repeat (4) @(posedge aclk);
    start_run(32'd1, 64'd0, 6'd0);
    for (int i = 0; i < N; i++) d[i*32 +: 32] = 32'(i + 100);
    push(d, 1'b1);
    send_beat(d, 1'b1);
    wait_done("t6", 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
